reg_file_param: RTL and testbench

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param.sv | 83 ++++++++
 tb/tb_reg_file_param.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parameterised register file: one write port, two tri-stated combinational read
// ports, optional hard-wired zero register, optional write bypass and a sequential clear sweep.
module reg_file_param #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] Din,
  input  logic [AW-1:0]    RA,
  input  logic [AW-1:0]    RB,
  input  logic             oeA,
  input  logic             oeB,
  input  logic             clr,
  output logic [WIDTH-1:0] DA,
  output logic [WIDTH-1:0] DB,
  output logic             busy,
  output logic             wr_drop
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t           state;
  logic [AW-1:0]    ptr;
  logic [WIDTH-1:0] regs [DEPTH];
  logic             wrZero;
  logic             wrLive;
  logic [WIDTH-1:0] rdA;
  logic [WIDTH-1:0] rdB;

  assign wrZero = (ZERO_R0 != 0) && (WA == '0);
  // a write only lands (and only forwards) when the sweep is idle and not being reset
  assign wrLive = ld && (state == IDLE) && !reset && !wrZero;

  always_comb begin
    rdA = regs[RA];
    rdB = regs[RB];
    if ((BYPASS != 0) && wrLive && (RA == WA)) rdA = Din;
    if ((BYPASS != 0) && wrLive && (RB == WA)) rdB = Din;
    if ((ZERO_R0 != 0) && (RA == '0)) rdA = '0;
    if ((ZERO_R0 != 0) && (RB == '0)) rdB = '0;
  end

  assign DA   = oeA ? rdA : {WIDTH{1'bz}};
  assign DB   = oeB ? rdB : {WIDTH{1'bz}};
  assign busy = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      wr_drop <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      wr_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (ld && !wrZero) regs[WA] <= Din;
          if (clr) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          // clr is deliberately ignored here so a sweep never restarts
          regs[ptr] <= '0;
          ptr       <= ptr + 1'b1;
          wr_drop   <= ld;
          if (ptr == LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: three instances (default, no bypass, zero r0)
// share stimulus and are compared against an array-based reference model.
module tb_reg_file_param;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0, ld = 1'b0, clr = 1'b0, oeA = 1'b0, oeB = 1'b0;
  logic [2:0]  WA = '0, RA = '0, RB = '0;
  logic [15:0] Din = '0;
  wire  [15:0] daDef, dbDef, daNb, dbNb, daZ, dbZ;
  logic        busyDef, busyNb, busyZ, dropDef, dropNb, dropZ;

  reg_file_param #(.WIDTH(16), .DEPTH(8), .ZERO_R0(0), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .ld(ld), .WA(WA), .Din(Din), .RA(RA), .RB(RB),
    .oeA(oeA), .oeB(oeB), .clr(clr), .DA(daDef), .DB(dbDef), .busy(busyDef), .wr_drop(dropDef));

  reg_file_param #(.WIDTH(16), .DEPTH(8), .ZERO_R0(0), .BYPASS(0)) dutNb (
    .clk(clk), .reset(reset), .ld(ld), .WA(WA), .Din(Din), .RA(RA), .RB(RB),
    .oeA(oeA), .oeB(oeB), .clr(clr), .DA(daNb), .DB(dbNb), .busy(busyNb), .wr_drop(dropNb));

  reg_file_param #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1), .BYPASS(1)) dutZ (
    .clk(clk), .reset(reset), .ld(ld), .WA(WA), .Din(Din), .RA(RA), .RB(RB),
    .oeA(oeA), .oeB(oeB), .clr(clr), .DA(daZ), .DB(dbZ), .busy(busyZ), .wr_drop(dropZ));

  initial forever #5 clk = ~clk;

  typedef struct {int cyc; int sel; logic [15:0] exp;} item_t;
  item_t       q[$];
  logic [15:0] mem [D];
  bit          known = 1'b0;
  int          sweepIdx = -1;
  bit          dropExp = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  // model view of a read port: zero register first, then same-cycle forwarding, then storage
  function automatic logic [15:0] readExp(input logic [2:0] a, input bit byp, input bit zero);
    if (zero && a == 3'd0) return 16'h0;
    if (byp && sweepIdx < 0 && ld && !reset && a == WA) return Din;
    return mem[a];
  endfunction

  function automatic void push(input int sel, input logic [15:0] exp);
    item_t it;
    it.cyc = cyc; it.sel = sel; it.exp = exp;
    q.push_back(it);
  endfunction

  task automatic applyStimulus(input bit r, input bit l, input bit c, input logic [2:0] wa,
                               input logic [2:0] ra, input logic [2:0] rb,
                               input logic [15:0] din, input bit oa, input bit ob);
    reset = r; ld = l; clr = c; WA = wa; RA = ra; RB = rb; Din = din; oeA = oa; oeB = ob;
    if (known) begin
      push(6, {15'h0, sweepIdx >= 0});
      push(7, {15'h0, dropExp});
      if (oa) begin
        push(0, readExp(ra, 1, 0)); push(2, readExp(ra, 0, 0)); push(4, readExp(ra, 1, 1));
      end
      if (ob) begin
        push(1, readExp(rb, 1, 0)); push(3, readExp(rb, 0, 0)); push(5, readExp(rb, 1, 1));
      end
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < D; i++) mem[i] = 16'h0;
      sweepIdx = -1; dropExp = 1'b0; known = 1'b1;
    end else if (known) begin
      if (sweepIdx >= 0) begin
        dropExp = l;
        mem[sweepIdx] = 16'h0;
        sweepIdx++;
        if (sweepIdx == D) sweepIdx = -1;
      end else begin
        dropExp = 1'b0;
        if (l) mem[wa] = din;
        if (c) sweepIdx = 0;
      end
    end
    #1;
    cyc++;
  endtask

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput();
    item_t it;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      it = q.pop_front();
      if (it.cyc < cyc) begin
        total++; bad++;
        $display("[TB] FAIL stale sel=%0d cyc=%0d actual=none required=%h", it.sel, it.cyc, it.exp);
      end else begin
        case (it.sel)
          0: cmp("DA_def", daDef, it.exp);
          1: cmp("DB_def", dbDef, it.exp);
          2: cmp("DA_nobyp", daNb, it.exp);
          3: cmp("DB_nobyp", dbNb, it.exp);
          4: cmp("DA_zero", daZ, it.exp);
          5: cmp("DB_zero", dbZ, it.exp);
          6: begin
            cmp("busy_def", {15'h0, busyDef}, it.exp);
            cmp("busy_nobyp", {15'h0, busyNb}, it.exp);
            cmp("busy_zero", {15'h0, busyZ}, it.exp);
          end
          default: begin
            cmp("wr_drop_def", {15'h0, dropDef}, it.exp);
            cmp("wr_drop_nobyp", {15'h0, dropNb}, it.exp);
            cmp("wr_drop_zero", {15'h0, dropZ}, it.exp);
          end
        endcase
      end
    end
  endtask

  always @(negedge clk) checkOutput();

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 16'h0, 1, 1);
    applyStimulus(1, 1, 1, 3, 0, 0, 16'h5555, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 7, 16'h0, 1, 1);

    applyStimulus(0, 1, 0, 3, 0, 0, 16'h1234, 0, 0);
    applyStimulus(0, 1, 0, 5, 0, 0, 16'hBEEF, 0, 0);
    applyStimulus(0, 0, 0, 0, 3, 5, 16'h0, 1, 1);
    applyStimulus(0, 0, 0, 0, 3, 5, 16'h0, 0, 1);

    applyStimulus(0, 1, 0, 2, 2, 2, 16'hA5A5, 1, 1);
    applyStimulus(0, 0, 0, 0, 2, 2, 16'h0, 1, 1);

    for (int i = 0; i < D; i++)
      applyStimulus(0, 1, 0, 3'(i), 3'(i), 7, 16'h1111 * 16'(i + 1), 1, 1);
    applyStimulus(0, 0, 1, 0, 7, 6, 16'h0, 1, 1);
    for (int k = 0; k < D; k++)
      applyStimulus(0, k == 2, k == 4, 6, 7, 6, 16'h7777, 1, 1);
    applyStimulus(0, 0, 0, 0, 7, 6, 16'h0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 16'h0, 1, 1);

    applyStimulus(0, 1, 0, 0, 0, 0, 16'hFFFF, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 16'h0, 1, 1);

    for (int i = 0; i < D; i++)
      applyStimulus(0, 1, 0, 3'(i), 0, 0, 16'h0F0F + 16'(i), 0, 0);
    applyStimulus(0, 1, 1, 4, 4, 5, 16'h9999, 1, 1);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 7, 16'h0, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 7, 16'h0, 1, 1);
    applyStimulus(0, 1, 0, 1, 1, 7, 16'h4242, 1, 1);
    applyStimulus(0, 0, 0, 0, 1, 6, 16'h0, 1, 1);

    for (int n = 0; n < 400; n++)
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 15) == 0, 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

    applyStimulus(0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    if (q.size() != 0) begin
      total++; bad++;
      $display("[TB] FAIL drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
